// File: rtl/icache_direct_pkg.sv
// Shared defaults, state encoding and helpers for the direct-mapped instruction cache.
package icache_direct_pkg;
   localparam int ICACHE_LINES    = 64;
   localparam int ICACHE_WPL      = 4;
   localparam int ICACHE_READ_LAT = 1;
   localparam int ICACHE_BYTE_W   = 2;

   typedef enum logic {
      ST_IDLE   = 1'b0,
      ST_REFILL = 1'b1
   } icache_state_e;

   // Bit position where the line index starts, and where the tag starts.
   function automatic int idx_lsb(input int wpl);
      return ICACHE_BYTE_W + $clog2(wpl);
   endfunction

   function automatic int tag_lsb(input int lines, input int wpl);
      return idx_lsb(wpl) + $clog2(lines);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] v);
      return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/icache_refill_ctrl.sv
// Line refill sequencer: issues word addresses to memory and tracks which
// returning word belongs where, READ_LAT cycles behind the issue.
module icache_refill_ctrl
   import icache_direct_pkg::*;
#(
   parameter int  WORDS_PER_LINE = ICACHE_WPL,
   parameter int  READ_LAT       = ICACHE_READ_LAT,
   localparam int OFF_W          = $clog2(WORDS_PER_LINE)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             abort,
   input  logic [31:0]      base,
   output logic [31:0]      mem_addr,
   output logic             wr_en,
   output logic [OFF_W-1:0] wr_word,
   output logic             last_word
);
   localparam logic [OFF_W:0]   CNT_LOAD = (OFF_W+1)'(WORDS_PER_LINE);
   localparam logic [OFF_W:0]   CNT_ONE  = (OFF_W+1)'(1);
   localparam logic [OFF_W-1:0] IDX_ONE  = OFF_W'(1);

   logic [OFF_W:0]      issue_left;
   logic [READ_LAT-1:0] rd_pipe;
   logic [READ_LAT:0]   rd_shift;
   logic [OFF_W-1:0]    recv_idx;
   logic                issue_active;
   logic                rd_valid;

   // The top bit of the shift chain is the issue flag delayed READ_LAT cycles.
   assign issue_active = (issue_left != '0);
   assign rd_shift     = {rd_pipe, issue_active};
   assign rd_valid     = rd_shift[READ_LAT];
   assign wr_en        = rd_valid & ~abort;
   assign wr_word      = recv_idx;
   assign last_word    = wr_en & (recv_idx == '1);

   always_ff @(posedge clk) begin
      if (rst) begin
         mem_addr   <= '0;
         issue_left <= '0;
         rd_pipe    <= '0;
         recv_idx   <= '0;
      end else if (abort) begin
         issue_left <= '0;
         rd_pipe    <= '0;
         recv_idx   <= '0;
      end else begin
         rd_pipe <= rd_shift[READ_LAT-1:0];
         if (start) begin
            mem_addr   <= base;
            issue_left <= CNT_LOAD;
            recv_idx   <= '0;
         end else if (issue_active) begin
            issue_left <= issue_left - CNT_ONE;
            if (issue_left != CNT_ONE) begin
               mem_addr <= mem_addr + 32'd4;
            end
         end
         if (rd_valid) begin
            recv_idx <= recv_idx + IDX_ONE;
         end
      end
   end
endmodule

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: same-cycle hits, word-by-word
// line refill on a miss, whole-cache invalidate.
//
//   state     | meaning
//   ST_IDLE   | look up cpu_addr; hit returns data, miss starts a refill
//   ST_REFILL | fetching the latched line from memory, CPU stalled
module icache_direct
   import icache_direct_pkg::*;
#(
   parameter int LINES          = ICACHE_LINES,
   parameter int WORDS_PER_LINE = ICACHE_WPL,
   parameter int READ_LAT       = ICACHE_READ_LAT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        cpu_req,
   input  logic [31:0] cpu_addr,
   output logic [31:0] cpu_inst,
   output logic        cpu_valid,
   output logic        icache_stall,
   input  logic        inv,
   output logic [31:0] mem_addr,
   input  logic [31:0] mem_rdata,
   output logic [31:0] hit_count,
   output logic [31:0] miss_count
);
   localparam int OFF_W    = $clog2(WORDS_PER_LINE);
   localparam int IDX_W    = $clog2(LINES);
   localparam int LINE_LSB = idx_lsb(WORDS_PER_LINE);
   localparam int TAG_LSB  = tag_lsb(LINES, WORDS_PER_LINE);
   localparam int TAG_W    = 32 - TAG_LSB;
   localparam int LINE_W   = 32 - LINE_LSB;

   logic [LINES-1:0] valid_q;
   logic [TAG_W-1:0] tag_mem  [LINES];
   logic [31:0]      data_mem [LINES][WORDS_PER_LINE];

   icache_state_e    state_q;
   icache_state_e    state_d;
   logic [LINE_W-1:0] line_q;

   logic [OFF_W-1:0] req_off;
   logic [IDX_W-1:0] req_idx;
   logic [TAG_W-1:0] req_tag;
   logic [IDX_W-1:0] fill_idx;
   logic [TAG_W-1:0] fill_tag;
   logic [31:0]      fill_base;
   logic             hit;
   logic             start;
   logic             abort;
   logic             wr_en;
   logic             last_word;
   logic [OFF_W-1:0] wr_word;
   logic             addr_unused;

   assign req_off     = cpu_addr[ICACHE_BYTE_W +: OFF_W];
   assign req_idx     = cpu_addr[LINE_LSB +: IDX_W];
   assign req_tag     = cpu_addr[31:TAG_LSB];
   assign addr_unused = ^cpu_addr[ICACHE_BYTE_W-1:0];
   assign fill_idx    = line_q[IDX_W-1:0];
   assign fill_tag    = line_q[LINE_W-1:IDX_W];
   assign fill_base   = {cpu_addr[31:LINE_LSB], {LINE_LSB{1'b0}}};
   assign hit         = cpu_req & valid_q[req_idx] & (tag_mem[req_idx] == req_tag);

   icache_refill_ctrl #(
      .WORDS_PER_LINE (WORDS_PER_LINE),
      .READ_LAT       (READ_LAT)
   ) u_refill (
      .clk       (clk),
      .rst       (rst),
      .start     (start),
      .abort     (abort),
      .base      (fill_base),
      .mem_addr  (mem_addr),
      .wr_en     (wr_en),
      .wr_word   (wr_word),
      .last_word (last_word)
   );

   always_comb begin
      state_d      = state_q;
      cpu_valid    = 1'b0;
      cpu_inst     = '0;
      icache_stall = 1'b0;
      start        = 1'b0;
      abort        = 1'b0;
      if (rst) begin
         state_d = ST_IDLE;
      end else if (inv) begin
         // Nothing is returned this cycle, so a pending fetch must hold.
         abort        = 1'b1;
         state_d      = ST_IDLE;
         icache_stall = cpu_req | (state_q == ST_REFILL);
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (hit) begin
                  cpu_valid = 1'b1;
                  cpu_inst  = data_mem[req_idx][req_off];
               end else if (cpu_req) begin
                  icache_stall = 1'b1;
                  start        = 1'b1;
                  state_d      = ST_REFILL;
               end
            end
            ST_REFILL: begin
               icache_stall = 1'b1;
               if (last_word) begin
                  state_d = ST_IDLE;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         valid_q    <= '0;
         hit_count  <= '0;
         miss_count <= '0;
      end else begin
         state_q <= state_d;
         if (inv) begin
            valid_q <= '0;
         end else begin
            // Old line contents must never be seen while the refill overwrites them.
            if (start) begin
               valid_q[req_idx] <= 1'b0;
               miss_count       <= sat_inc(miss_count);
            end
            if (cpu_valid) begin
               hit_count <= sat_inc(hit_count);
            end
            if (last_word) begin
               valid_q[fill_idx] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (start) begin
         line_q <= cpu_addr[31:LINE_LSB];
      end
      if (wr_en) begin
         data_mem[fill_idx][wr_word] <= mem_rdata;
      end
      if (last_word) begin
         tag_mem[fill_idx] <= fill_tag;
      end
   end
endmodule

// File: tb/tb_icache_direct.sv
// Bench for icache_direct: directed vector table, hand-written refill corner
// cases, and random fetches against a resident-line reference model.
module tb_icache_direct;
   import icache_direct_pkg::*;

   localparam int W = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        cpu_req = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic        inv = 1'b0;
   logic [31:0] rd1 = '0;
   logic [31:0] cpu_inst1, mem_addr1, hit_count1, miss_count1;
   logic        cpu_valid1, stall1;

   logic        req2 = 1'b0;
   logic [31:0] addr2 = '0;
   logic        inv2 = 1'b0;
   logic [31:0] rd2 = '0;
   logic [31:0] p2 = '0;
   logic [31:0] cpu_inst2, mem_addr2, hit_count2, miss_count2;
   logic        cpu_valid2, stall2;

   int checks = 0;
   int errors = 0;
   int exp_h1 = 0, exp_m1 = 0, exp_h2 = 0, exp_m2 = 0;
   logic [31:0] salt = '0;

   typedef struct {
      logic [31:0] addr;
      bit          miss;
      logic [31:0] inst;
   } vec_t;
   vec_t vecs[6];

   logic [31:0] res_line [4];
   bit          res_ok   [4];

   always #5 clk = ~clk;

   icache_direct #(.LINES(64), .WORDS_PER_LINE(4), .READ_LAT(1)) dut (
      .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
      .cpu_inst(cpu_inst1), .cpu_valid(cpu_valid1), .icache_stall(stall1),
      .inv(inv), .mem_addr(mem_addr1), .mem_rdata(rd1),
      .hit_count(hit_count1), .miss_count(miss_count1)
   );

   icache_direct #(.LINES(64), .WORDS_PER_LINE(4), .READ_LAT(2)) dut2 (
      .clk(clk), .rst(rst), .cpu_req(req2), .cpu_addr(addr2),
      .cpu_inst(cpu_inst2), .cpu_valid(cpu_valid2), .icache_stall(stall2),
      .inv(inv2), .mem_addr(mem_addr2), .mem_rdata(rd2),
      .hit_count(hit_count2), .miss_count(miss_count2)
   );

   // Program memory: word n holds 0x1000_0000 + n, shifted by a reload salt.
   function automatic logic [31:0] memf(input logic [31:0] a);
      return 32'h1000_0000 + {2'b00, a[31:2]} + salt;
   endfunction

   always @(posedge clk) rd1 <= memf(mem_addr1);
   always @(posedge clk) begin
      p2  <= memf(mem_addr2);
      rd2 <= p2;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", nm, act, exp);
      end
   endtask

   task automatic fetch(input bit sel, input logic [31:0] a, input bit exp_miss,
                        input logic [31:0] exp_inst, input string nm);
      int stalls;
      bit got;
      logic [31:0] inst;
      int rl;
      rl = sel ? 2 : 1;
      if (sel) begin
         req2 = 1'b1; addr2 = a;
      end else begin
         cpu_req = 1'b1; cpu_addr = a;
      end
      stalls = 0; got = 1'b0; inst = '0;
      for (int c = 0; c < 40 && !got; c++) begin
         @(negedge clk);
         if (exp_miss && c >= 1 && c <= W)
            chk({nm, "_maddr"}, sel ? mem_addr2 : mem_addr1, (a & ~32'hF) + 32'(4 * (c - 1)));
         if (sel ? cpu_valid2 : cpu_valid1) begin
            got = 1'b1;
            inst = sel ? cpu_inst2 : cpu_inst1;
         end else if (sel ? stall2 : stall1) begin
            stalls++;
         end
         @(posedge clk); #1;
      end
      chk({nm, "_done"}, 32'(got), 32'd1);
      chk({nm, "_stalls"}, 32'(stalls), 32'(exp_miss ? W + rl + 1 : 0));
      chk({nm, "_inst"}, inst, exp_inst);
      if (sel) begin
         exp_h2++;
         if (exp_miss) exp_m2++;
         chk({nm, "_hits"}, hit_count2, 32'(exp_h2));
         chk({nm, "_misses"}, miss_count2, 32'(exp_m2));
      end else begin
         exp_h1++;
         if (exp_miss) exp_m1++;
         chk({nm, "_hits"}, hit_count1, 32'(exp_h1));
         chk({nm, "_misses"}, miss_count1, 32'(exp_m1));
      end
   endtask

   task automatic pulse_inv();
      cpu_req = 1'b0;
      inv = 1'b1;
      @(posedge clk); #1;
      inv = 1'b0;
      salt = salt + 32'h0010_0000;
      for (int i = 0; i < 4; i++) res_ok[i] = 1'b0;
   endtask

   initial begin
      int stalls;
      bit got;
      logic [31:0] inst;

      vecs[0] = '{32'h0000_0000, 1'b1, 32'h1000_0000};
      vecs[1] = '{32'h0000_0004, 1'b0, 32'h1000_0001};
      vecs[2] = '{32'h0000_0008, 1'b0, 32'h1000_0002};
      vecs[3] = '{32'h0000_000C, 1'b0, 32'h1000_0003};
      vecs[4] = '{32'h0000_0400, 1'b1, 32'h1000_0100};
      vecs[5] = '{32'h0000_0000, 1'b1, 32'h1000_0000};

      // Reset: requests are ignored while rst is high.
      cpu_req = 1'b1; req2 = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_valid", 32'(cpu_valid1), 32'd0);
      chk("rst_stall", 32'(stall1), 32'd0);
      chk("rst_stall2", 32'(stall2), 32'd0);
      @(posedge clk); #1;
      rst = 1'b0; cpu_req = 1'b0; req2 = 1'b0;
      @(negedge clk);
      chk("rst_maddr", mem_addr1, 32'd0);
      chk("rst_hits", hit_count1, 32'd0);
      chk("rst_misses", miss_count1, 32'd0);
      chk("idle_stall", 32'(stall1), 32'd0);
      @(posedge clk); #1;

      // Two-cycle read latency build.
      fetch(1'b1, 32'h0, 1'b1, 32'h1000_0000, "t6_miss");
      fetch(1'b1, 32'h8, 1'b0, 32'h1000_0002, "t6_hit");
      req2 = 1'b0;

      // Cold miss, hits within the line, then conflict misses at index 0.
      for (int i = 0; i < 6; i++)
         fetch(1'b0, vecs[i].addr, vecs[i].miss, vecs[i].inst, $sformatf("vec%0d", i));

      // Branch away in the middle of a refill.
      fetch(1'b0, 32'h400, 1'b1, 32'h1000_0100, "t4_pre");
      cpu_req = 1'b1; cpu_addr = 32'h0; got = 1'b0; stalls = 0; inst = '0;
      for (int c = 0; c < 60 && !got; c++) begin
         @(negedge clk);
         if (c >= 1 && c <= 4) chk("t4_maddr_a", mem_addr1, 32'(4 * (c - 1)));
         if (c >= 7 && c <= 10) chk("t4_maddr_b", mem_addr1, 32'h800 + 32'(4 * (c - 7)));
         if (cpu_valid1) begin
            got = 1'b1; inst = cpu_inst1;
         end else if (stall1) begin
            stalls++;
         end
         @(posedge clk); #1;
         if (c == 2) cpu_addr = 32'h800;
      end
      exp_m1 += 2; exp_h1 += 1;
      chk("t4_done", 32'(got), 32'd1);
      chk("t4_stalls", 32'(stalls), 32'd12);
      chk("t4_inst", inst, 32'h1000_0200);
      chk("t4_misses", miss_count1, 32'(exp_m1));
      fetch(1'b0, 32'h804, 1'b0, 32'h1000_0201, "t4_line");
      fetch(1'b0, 32'h0, 1'b1, 32'h1000_0000, "t4_conf");

      // Invalidate in the middle of a refill, memory reloaded afterwards.
      cpu_addr = 32'h400;
      @(negedge clk); chk("t5_stall0", 32'(stall1), 32'd1);
      @(posedge clk); #1;
      @(posedge clk); #1;
      @(posedge clk); #1; inv = 1'b1;
      @(negedge clk); chk("t5_inv_valid", 32'(cpu_valid1), 32'd0);
      @(posedge clk); #1; inv = 1'b0; cpu_req = 1'b0; salt = 32'h0100_0000;
      exp_m1++;
      @(negedge clk);
      chk("t5_after_stall", 32'(stall1), 32'd0);
      chk("t5_after_valid", 32'(cpu_valid1), 32'd0);
      chk("t5_misses", miss_count1, 32'(exp_m1));
      @(posedge clk); #1; cpu_req = 1'b1; cpu_addr = 32'h1000; inv = 1'b1;
      @(posedge clk); #1; inv = 1'b0; cpu_req = 1'b0;
      @(negedge clk);
      chk("t5_invmiss_cnt", miss_count1, 32'(exp_m1));
      chk("t5_invmiss_stall", 32'(stall1), 32'd0);
      @(posedge clk); #1;
      fetch(1'b0, 32'h0, 1'b1, memf(32'h0), "t5_refetch");
      fetch(1'b0, 32'h400, 1'b1, memf(32'h400), "t5_fill");
      for (int k = 1; k < 4; k++)
         fetch(1'b0, 32'h400 + 32'(4 * k), 1'b0, memf(32'h400 + 32'(4 * k)), "t5_word");

      // Random fetches over 4 tags x 4 indices with occasional reloads.
      pulse_inv();
      for (int n = 0; n < 120; n++) begin
         logic [31:0] a;
         int ix;
         bit m;
         if ($urandom_range(15) == 0) pulse_inv();
         a = 32'($urandom_range(3) << 10) | 32'($urandom_range(3) << 4) | 32'($urandom_range(3) << 2);
         ix = int'(a[5:4]);
         m = !(res_ok[ix] && res_line[ix] == (a >> 4));
         fetch(1'b0, a, m, memf(a), "rand");
         res_ok[ix] = 1'b1;
         res_line[ix] = a >> 4;
      end
      cpu_req = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end
endmodule
